count_seq_checker: RTL and testbench
====================================

// Module: count_seq_checker
// PURPOSE
//   Receive-side checker for the free-running counter stream on uo_out[7:0].
//   Samples a slowly changing WIDTH-bit input (e.g. another chip's counter top byte on ui_in).
//   Deglitches the input and locks once it sees LOCK_COUNT consecutive +1 increments.
//   While locked, flags and counts every out-of-sequence value; used for board-to-board link test.
// PARAMETERS
//   WIDTH       8  width of the observed counter value
//   LOCK_COUNT  4  consecutive correct increments required to lock (>=1)
//   ERR_CNT_W   8  width of saturating error counter
// PORTS
//   clk        in   1          system clock, all logic on rising edge
//   rst        in   1          synchronous reset, active-high
//   en         in   1          checker enable; 0 forces IDLE
//   clr_err    in   1          synchronous clear of err_count
//   din        in   WIDTH      observed counter value (changes slowly vs clk)
//   locked     out  1          1 while in LOCKED state (registered)
//   err_pulse  out  1          one-cycle pulse per sequence error while locked (registered)
//   err_count  out  ERR_CNT_W  saturating count of sequence errors (registered)
// BEHAVIOUR
//   Reset (rst=1 at edge):
//   - state=IDLE; d1, d2, last, run_cnt = 0; locked=0, err_pulse=0, err_count=0.
//   - rst has priority over en and clr_err.
//   Input pipeline:
//   - d1<=din, d2<=d1 every cycle.
//   - event = (d1==d2) && (d2!=last): new value stable for 2 samples.
//   - 1-cycle glitches never produce an event.
//   Expected next value: exp = last + 1 mod 2^WIDTH; all-ones -> 0 is a correct increment.
//   On every event in ACQUIRE/LOCKED: last<=d2.
//   FSM:
//   - IDLE: locked=0. When en=1: last<=d2, run_cnt<=0, go ACQUIRE.
//   - ACQUIRE, event with d2==exp: run_cnt+1; when the new value reaches LOCK_COUNT, go LOCKED.
//   - ACQUIRE, event with d2!=exp: run_cnt<=0. No error is counted.
//   - LOCKED, event with d2==exp: stay.
//   - LOCKED, event with d2!=exp: err_pulse<=1 for one cycle, err_count+1 (saturates at all-ones),
//     run_cnt<=0, go ACQUIRE.
//   - en=0 in any state: go IDLE at next edge; locked<=0, err_pulse<=0; err_count held.
//   Latency:
//   - din changes before edge k -> d1 at k, d2 at k+1, event during cycle k+1..k+2.
//   - locked/err_pulse/err_count update at edge k+2.
//   clr_err:
//   - err_count<=0.
//   - If an error increment occurs in the same cycle, clear wins (count=0); err_pulse still fires.
//   run_cnt width = $clog2(LOCK_COUNT+1). No other state.
// TESTING
//   T1 lock: rst, en=1, din=0x10,0x11,..,0x14, each held 4 clk -> locked=1 two edges after 0x14
//      is stable in d2; err_count=0.
//   T2 wrap: locked, din 0xFE,0xFF,0x00,0x01 (4 clk each) -> err_pulse never 1, locked stays 1.
//   T3 error: locked at 0x20, din 0x22 -> exactly one err_pulse, err_count=1, locked=0;
//      then 0x23..0x27 -> relock after 0x26.
//   T4 glitch: locked at 0x30, din 0x55 for 1 clk then 0x31 -> no err_pulse, locked stays 1.
//   T5 saturate/clear: ERR_CNT_W=2, force 5 locked errors -> err_count=3.
//      clr_err coincident with an error -> err_count=0, err_pulse=1.
//   T6 abort: rst=1 while LOCKED -> all outputs 0 next edge.
//      en=0 while LOCKED with err_count=2 -> locked=0, err_count stays 2.

Source files
------------

// File: rtl/count_seq_checker.sv
// Receive-side checker for a slowly changing counter stream: deglitches the
// input, locks after LOCK_COUNT consecutive +1 steps, then flags and counts breaks.
module count_seq_checker #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr_err,
    input  logic [WIDTH-1:0]     din,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam logic [RUN_W-1:0] LOCK_VAL = RUN_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_d1;
    logic [WIDTH-1:0]     r_d2;
    logic [WIDTH-1:0]     r_last;
    logic [RUN_W-1:0]     r_run_cnt;
    logic                 r_locked;
    logic                 r_err_pulse;
    logic [ERR_CNT_W-1:0] r_err_count;

    state_t               w_state_nxt;
    logic [WIDTH-1:0]     w_last_nxt;
    logic [RUN_W-1:0]     w_run_nxt;
    logic [RUN_W-1:0]     w_run_inc;
    logic                 w_err_pulse_nxt;
    logic                 w_err_inc;
    logic [ERR_CNT_W-1:0] w_err_count_nxt;
    logic [WIDTH-1:0]     w_exp;
    logic                 w_event;
    logic                 w_match;

    // A new value counts only once it has been seen on two consecutive samples.
    assign w_event   = (r_d1 == r_d2) && (r_d2 != r_last);
    assign w_exp     = r_last + WIDTH'(1);
    assign w_match   = (r_d2 == w_exp);
    assign w_run_inc = r_run_cnt + RUN_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_run_nxt       = r_run_cnt;
        w_err_pulse_nxt = 1'b0;
        w_err_inc       = 1'b0;

        if (!en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_last_nxt  = r_d2;
                    w_run_nxt   = '0;
                    w_state_nxt = ACQUIRE;
                end
                ACQUIRE: begin
                    if (w_event) begin
                        w_last_nxt = r_d2;
                        if (w_match) begin
                            w_run_nxt = w_run_inc;
                            if (w_run_inc == LOCK_VAL) begin
                                w_state_nxt = LOCKED;
                            end
                        end else begin
                            w_run_nxt = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (w_event) begin
                        w_last_nxt = r_d2;
                        if (!w_match) begin
                            w_err_pulse_nxt = 1'b1;
                            w_err_inc       = 1'b1;
                            w_run_nxt       = '0;
                            w_state_nxt     = ACQUIRE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end

        // Clear takes priority over a simultaneous error increment.
        if (clr_err) begin
            w_err_count_nxt = '0;
        end else if (w_err_inc && !(&r_err_count)) begin
            w_err_count_nxt = r_err_count + ERR_CNT_W'(1);
        end else begin
            w_err_count_nxt = r_err_count;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_d1        <= '0;
            r_d2        <= '0;
            r_last      <= '0;
            r_run_cnt   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_d1        <= din;
            r_d2        <= r_d1;
            r_last      <= w_last_nxt;
            r_run_cnt   <= w_run_nxt;
            r_locked    <= (w_state_nxt == LOCKED);
            r_err_pulse <= w_err_pulse_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed table-driven bench for count_seq_checker; a second instance with a
// 2-bit error counter covers saturation.
module tb_count_seq_checker;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr_err;
    logic [7:0] din;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic       locked2;
    logic       err_pulse2;
    logic [1:0] err_count2;

    int n_tests;
    int n_fail;
    int pulses;
    int pulses2;

    count_seq_checker dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr_err   (clr_err),
        .din       (din),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    count_seq_checker #(.ERR_CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr_err   (clr_err),
        .din       (din),
        .locked    (locked2),
        .err_pulse (err_pulse2),
        .err_count (err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       clr;
        logic [7:0] din;
        int         n;
        logic       lk;
        int         pulses;
        int         cnt;
        int         cnt2;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic e, input logic c, input logic [7:0] d,
                       input int n, input logic lk, input int p, input int cnt, input int cnt2);
        vec_t v;
        v.rst = r; v.en = e; v.clr = c; v.din = d; v.n = n;
        v.lk = lk; v.pulses = p; v.cnt = cnt; v.cnt2 = cnt2;
        tv.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // Advance n clocks, sampling on the falling edge and counting error pulses.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            pulses  += int'(err_pulse);
            pulses2 += int'(err_pulse2);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; en = 1'b0; clr_err = 1'b0; din = 8'h00;

        //   rst  en   clr  din    n  lock pls cnt cnt2
        add(1'b1,1'b0,1'b0,8'h00, 2, 1'b0, 0, 0, 0);
        add(1'b0,1'b1,1'b0,8'h10, 4, 1'b0, 0, 0, 0);
        add(1'b0,1'b1,1'b0,8'h11, 4, 1'b0, 0, 0, 0);
        add(1'b0,1'b1,1'b0,8'h12, 4, 1'b0, 0, 0, 0);
        add(1'b0,1'b1,1'b0,8'h13, 4, 1'b0, 0, 0, 0);
        add(1'b0,1'b1,1'b0,8'h14, 4, 1'b1, 0, 0, 0);
        add(1'b0,1'b1,1'b0,8'h55, 1, 1'b1, 0, 0, 0);  // glitch
        add(1'b0,1'b1,1'b0,8'h15, 4, 1'b1, 0, 0, 0);
        add(1'b0,1'b1,1'b0,8'h17, 4, 1'b0, 1, 1, 1);  // skipped value
        add(1'b0,1'b1,1'b0,8'h18, 4, 1'b0, 0, 1, 1);
        add(1'b0,1'b1,1'b0,8'h19, 4, 1'b0, 0, 1, 1);
        add(1'b0,1'b1,1'b0,8'h1A, 4, 1'b0, 0, 1, 1);
        add(1'b0,1'b1,1'b0,8'h1B, 4, 1'b1, 0, 1, 1);
        add(1'b0,1'b1,1'b0,8'hFB, 4, 1'b0, 1, 2, 2);
        add(1'b0,1'b1,1'b0,8'hFC, 4, 1'b0, 0, 2, 2);
        add(1'b0,1'b1,1'b0,8'hFD, 4, 1'b0, 0, 2, 2);
        add(1'b0,1'b1,1'b0,8'hFE, 4, 1'b0, 0, 2, 2);
        add(1'b0,1'b1,1'b0,8'hFF, 4, 1'b1, 0, 2, 2);
        add(1'b0,1'b1,1'b0,8'h00, 4, 1'b1, 0, 2, 2);  // wrap while locked
        add(1'b0,1'b1,1'b0,8'h01, 4, 1'b1, 0, 2, 2);
        add(1'b0,1'b0,1'b0,8'h01, 4, 1'b0, 0, 2, 2);  // disable
        add(1'b0,1'b1,1'b0,8'h02, 4, 1'b0, 0, 2, 2);
        add(1'b0,1'b1,1'b0,8'h03, 4, 1'b0, 0, 2, 2);
        add(1'b0,1'b1,1'b0,8'h04, 4, 1'b0, 0, 2, 2);
        add(1'b0,1'b1,1'b0,8'h05, 4, 1'b1, 0, 2, 2);
        add(1'b0,1'b1,1'b0,8'h07, 4, 1'b0, 1, 3, 3);
        add(1'b0,1'b1,1'b0,8'h08, 4, 1'b0, 0, 3, 3);
        add(1'b0,1'b1,1'b0,8'h09, 4, 1'b0, 0, 3, 3);
        add(1'b0,1'b1,1'b0,8'h0A, 4, 1'b0, 0, 3, 3);
        add(1'b0,1'b1,1'b0,8'h0B, 4, 1'b1, 0, 3, 3);
        add(1'b0,1'b1,1'b0,8'h0D, 4, 1'b0, 1, 4, 3);  // 2-bit counter saturates
        add(1'b0,1'b1,1'b0,8'h0E, 4, 1'b0, 0, 4, 3);
        add(1'b0,1'b1,1'b0,8'h0F, 4, 1'b0, 0, 4, 3);
        add(1'b0,1'b1,1'b0,8'h10, 4, 1'b0, 0, 4, 3);
        add(1'b0,1'b1,1'b0,8'h11, 4, 1'b1, 0, 4, 3);
        add(1'b1,1'b1,1'b0,8'h11, 1, 1'b0, 0, 0, 0);  // reset while locked
        add(1'b0,1'b1,1'b0,8'h11, 4, 1'b0, 0, 0, 0);
        add(1'b0,1'b1,1'b0,8'h12, 4, 1'b0, 0, 0, 0);
        add(1'b0,1'b1,1'b0,8'h13, 4, 1'b0, 0, 0, 0);
        add(1'b0,1'b1,1'b0,8'h14, 4, 1'b0, 0, 0, 0);
        add(1'b0,1'b1,1'b0,8'h15, 4, 1'b1, 0, 0, 0);
        add(1'b0,1'b1,1'b0,8'h17, 4, 1'b0, 1, 1, 1);
        add(1'b0,1'b1,1'b0,8'h18, 4, 1'b0, 0, 1, 1);
        add(1'b0,1'b1,1'b0,8'h19, 4, 1'b0, 0, 1, 1);
        add(1'b0,1'b1,1'b0,8'h1A, 4, 1'b0, 0, 1, 1);
        add(1'b0,1'b1,1'b0,8'h1B, 4, 1'b1, 0, 1, 1);

        for (int i = 0; i < tv.size(); i++) begin
            rst = tv[i].rst; en = tv[i].en; clr_err = tv[i].clr; din = tv[i].din;
            pulses = 0; pulses2 = 0;
            run(tv[i].n);
            check("locked",     i, int'(locked),     int'(tv[i].lk));
            check("locked_w2",  i, int'(locked2),    int'(tv[i].lk));
            check("err_pulses", i, pulses,           tv[i].pulses);
            check("pulses_w2",  i, pulses2,          tv[i].pulses);
            check("err_count",  i, int'(err_count),  tv[i].cnt);
            check("count_w2",   i, int'(err_count2), tv[i].cnt2);
        end

        // Error edge lands two edges after din changes; raise clr_err on exactly that edge.
        rst = 1'b0; en = 1'b1; clr_err = 1'b0; din = 8'h1D;
        pulses = 0; pulses2 = 0;
        run(2);
        check("pre_clr_pulse", 100, pulses,           0);
        check("pre_clr_count", 100, int'(err_count),  1);
        clr_err = 1'b1;
        run(1);
        clr_err = 1'b0;
        run(1);
        check("coinc_pulse",    101, pulses,           1);
        check("coinc_pulse_w2", 101, pulses2,          1);
        check("coinc_count",    101, int'(err_count),  0);
        check("coinc_count_w2", 101, int'(err_count2), 0);
        check("coinc_locked",   101, int'(locked),     0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
